// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter_if
// Brief    : Requester and memory-side signal bundle for dmem_arbiter.
// Revision : 1.0
// ============================================================================
interface dmem_arbiter_if;
  logic        p0_req;
  logic        p0_we;
  logic [31:0] p0_addr;
  logic [31:0] p0_wdata;
  logic        p0_gnt;
  logic        p0_rvalid;
  logic [31:0] p0_rdata;
  logic        p0_err;

  logic        p1_req;
  logic        p1_we;
  logic        p1_lock;
  logic [31:0] p1_addr;
  logic [31:0] p1_wdata;
  logic        p1_gnt;
  logic        p1_rvalid;
  logic [31:0] p1_rdata;
  logic        p1_err;

  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_gnt, p0_rvalid, p0_rdata, p0_err,
    input  p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
    output p1_gnt, p1_rvalid, p1_rdata, p1_err,
    output mem_wr_en, mem_addr, mem_wr_data,
    input  mem_rd_data
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_gnt, p0_rvalid, p0_rdata, p0_err,
    output p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
    input  p1_gnt, p1_rvalid, p1_rdata, p1_err,
    input  mem_wr_en, mem_addr, mem_wr_data,
    output mem_rd_data
  );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Round-robin two-port arbiter for a single-port data memory with
//            bounded port-1 burst lock and out-of-range protection.
// Revision : 1.0
// ============================================================================
module dmem_arbiter #(
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave bus
);

  localparam int unsigned          c_cnt_w   = $clog2(MAX_BURST + 1);
  localparam logic [c_cnt_w-1:0]   c_max_cnt = c_cnt_w'(MAX_BURST);
  localparam logic [c_cnt_w-1:0]   c_one     = c_cnt_w'(1);
  localparam logic [31:0]          c_depth   = 32'(DEPTH);
  // A burst limit of one leaves nothing to lock beyond the entering grant.
  localparam bit                   c_lock_en = (MAX_BURST > 1);

  typedef enum logic [0:0] {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic                 rr_ptr_q, rr_ptr_d;
  logic [c_cnt_w-1:0]   burst_cnt_q, burst_cnt_d;

  logic                 p0_rvalid_q, p1_rvalid_q;
  logic                 p0_err_q, p1_err_q;
  logic [31:0]          p0_rdata_q, p1_rdata_q;

  logic                 w_p0_in_range, w_p1_in_range;
  logic                 w_gnt0_raw, w_gnt1_raw;
  logic                 w_gnt0, w_gnt1;
  logic                 w_lock_hold;
  logic                 w_rr_eff;
  logic [c_cnt_w-1:0]   w_cnt_inc;
  logic [31:0]          w_p0_rdata_d, w_p1_rdata_d;

  assign w_p0_in_range = ({2'b00, bus.p0_addr[31:2]} < c_depth);
  assign w_p1_in_range = ({2'b00, bus.p1_addr[31:2]} < c_depth);

  assign w_lock_hold = (state_q == ST_LOCK) && bus.p1_req && bus.p1_lock;
  // Leaving a burst always hands priority back to port 0.
  assign w_rr_eff    = (state_q == ST_LOCK) ? 1'b0 : rr_ptr_q;
  assign w_cnt_inc   = burst_cnt_q + c_one;

  always_comb begin
    w_gnt0_raw  = 1'b0;
    w_gnt1_raw  = 1'b0;
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;

    if (w_lock_hold) begin
      w_gnt1_raw = 1'b1;
      rr_ptr_d   = 1'b0;
      if (w_cnt_inc >= c_max_cnt) begin
        state_d     = ST_ARB;
        burst_cnt_d = '0;
      end else begin
        burst_cnt_d = w_cnt_inc;
      end
    end else begin
      state_d     = ST_ARB;
      burst_cnt_d = '0;
      if (bus.p0_req && (!bus.p1_req || !w_rr_eff)) begin
        w_gnt0_raw = 1'b1;
        rr_ptr_d   = 1'b1;
      end else if (bus.p1_req) begin
        w_gnt1_raw = 1'b1;
        rr_ptr_d   = 1'b0;
        if (bus.p1_lock && c_lock_en) begin
          state_d     = ST_LOCK;
          burst_cnt_d = c_one;
        end
      end
    end
  end

  // Grants are killed combinationally so nothing reaches memory during reset.
  assign w_gnt0 = w_gnt0_raw & rst_n;
  assign w_gnt1 = w_gnt1_raw & rst_n;

  assign bus.p0_gnt      = w_gnt0;
  assign bus.p1_gnt      = w_gnt1;
  assign bus.mem_addr    = w_gnt1 ? bus.p1_addr  : bus.p0_addr;
  assign bus.mem_wr_data = w_gnt1 ? bus.p1_wdata : bus.p0_wdata;
  assign bus.mem_wr_en   = (w_gnt0 & bus.p0_we & w_p0_in_range)
                         | (w_gnt1 & bus.p1_we & w_p1_in_range);

  assign w_p0_rdata_d = (!bus.p0_we && w_p0_in_range) ? bus.mem_rd_data : 32'h0;
  assign w_p1_rdata_d = (!bus.p1_we && w_p1_in_range) ? bus.mem_rd_data : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ARB;
      rr_ptr_q    <= 1'b0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_rvalid_q <= 1'b0;
      p0_err_q    <= 1'b0;
      p0_rdata_q  <= 32'h0;
    end else begin
      p0_rvalid_q <= w_gnt0;
      p0_err_q    <= w_gnt0 & !w_p0_in_range;
      if (w_gnt0) begin
        p0_rdata_q <= w_p0_rdata_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_rvalid_q <= 1'b0;
      p1_err_q    <= 1'b0;
      p1_rdata_q  <= 32'h0;
    end else begin
      p1_rvalid_q <= w_gnt1;
      p1_err_q    <= w_gnt1 & !w_p1_in_range;
      if (w_gnt1) begin
        p1_rdata_q <= w_p1_rdata_d;
      end
    end
  end

  assign bus.p0_rvalid = p0_rvalid_q;
  assign bus.p0_err    = p0_err_q;
  assign bus.p0_rdata  = p0_rdata_q;
  assign bus.p1_rvalid = p1_rvalid_q;
  assign bus.p1_err    = p1_err_q;
  assign bus.p1_rdata  = p1_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Directed self-checking bench for dmem_arbiter with a 64-word memory.
// Revision : 1.0
// ============================================================================
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if bus ();

  dmem_arbiter #(
    .DEPTH     (64),
    .MAX_BURST (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem [64];
  logic        mem_clr;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + 32'(i);
    end else if (bus.mem_wr_en) begin
      mem[bus.mem_addr[7:2]] <= bus.mem_wr_data;
    end
  end

  assign bus.mem_rd_data = mem[bus.mem_addr[7:2]];

  task chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task idle();
    bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = 32'h0; bus.p0_wdata = 32'h0;
    bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_lock = 1'b0;
    bus.p1_addr = 32'h0; bus.p1_wdata = 32'h0;
  endtask

  task tick();
    @(posedge clk);
    #1;
  endtask

  task do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  logic [19:0] exp_p1;
  int          wait_cnt;
  int          max_wait;

  initial begin
    // Reset with a pending p0 write: nothing may be granted or written.
    rst_n   = 1'b0;
    mem_clr = 1'b1;
    idle();
    bus.p0_req = 1'b1; bus.p0_we = 1'b1; bus.p0_addr = 32'h10;
    #1;
    chk("rst_p0_gnt", bus.p0_gnt, 0);
    chk("rst_p1_gnt", bus.p1_gnt, 0);
    chk("rst_wr_en", bus.mem_wr_en, 0);
    chk("rst_p0_rvalid", bus.p0_rvalid, 0);
    chk("rst_p1_rvalid", bus.p1_rvalid, 0);
    chk("rst_p0_rdata", bus.p0_rdata, 0);
    chk("rst_p0_err", bus.p0_err, 0);
    tick();
    tick();
    mem_clr = 1'b0;
    idle();
    rst_n = 1'b1;

    // p0 write then read of 0x10
    bus.p0_req = 1'b1; bus.p0_we = 1'b1; bus.p0_addr = 32'h10; bus.p0_wdata = 32'hDEADBEEF;
    #1;
    chk("t1_w_gnt0", bus.p0_gnt, 1);
    chk("t1_w_gnt1", bus.p1_gnt, 0);
    chk("t1_w_wr_en", bus.mem_wr_en, 1);
    chk("t1_w_addr", bus.mem_addr, 32'h10);
    chk("t1_w_wdata", bus.mem_wr_data, 32'hDEADBEEF);
    tick();
    chk("t1_w_rvalid", bus.p0_rvalid, 1);
    chk("t1_w_rdata", bus.p0_rdata, 0);
    chk("t1_w_err", bus.p0_err, 0);
    bus.p0_we = 1'b0;
    #1;
    chk("t1_r_gnt0", bus.p0_gnt, 1);
    chk("t1_r_wr_en", bus.mem_wr_en, 0);
    tick();
    chk("t1_r_rvalid", bus.p0_rvalid, 1);
    chk("t1_r_rdata", bus.p0_rdata, 32'hDEADBEEF);
    chk("t1_r_err", bus.p0_err, 0);
    idle();
    tick();
    chk("t1_idle_rvalid", bus.p0_rvalid, 0);
    chk("t1_idle_rdata_hold", bus.p0_rdata, 32'hDEADBEEF);

    // Continuous contention without lock alternates starting with p0
    do_reset();
    bus.p0_req = 1'b1; bus.p0_addr = 32'h10;
    bus.p1_req = 1'b1; bus.p1_addr = 32'h0;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("t2_gnt0", bus.p0_gnt, (i % 2 == 0) ? 1 : 0);
      chk("t2_gnt1", bus.p1_gnt, (i % 2 == 1) ? 1 : 0);
      tick();
      chk("t2_rvalid0", bus.p0_rvalid, (i % 2 == 0) ? 1 : 0);
      chk("t2_rvalid1", bus.p1_rvalid, (i % 2 == 1) ? 1 : 0);
    end
    chk("t2_p0_rdata", bus.p0_rdata, 32'hDEADBEEF);
    chk("t2_p1_rdata", bus.p1_rdata, 32'h1000_0000);

    // Locked p1 bursts versus a persistent p0 request
    do_reset();
    bus.p0_req = 1'b1; bus.p0_addr = 32'h4;
    bus.p1_req = 1'b1; bus.p1_lock = 1'b1; bus.p1_addr = 32'h8;
    exp_p1   = 20'b10111111110111111110;
    wait_cnt = 0;
    max_wait = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("t3_gnt1", bus.p1_gnt, exp_p1[i]);
      chk("t3_gnt0", bus.p0_gnt, !exp_p1[i]);
      if (bus.p0_gnt) wait_cnt = 0;
      else wait_cnt++;
      if (wait_cnt > max_wait) max_wait = wait_cnt;
      tick();
    end
    chk("t3_max_p0_wait", max_wait, 8);
    bus.p1_lock = 1'b0;
    #1;
    chk("t3_unlock_gnt0", bus.p0_gnt, 1);
    chk("t3_unlock_gnt1", bus.p1_gnt, 0);
    tick();

    // Out-of-range write from p1 and boundary indices
    idle();
    bus.p1_req = 1'b1; bus.p1_we = 1'b1; bus.p1_addr = 32'h100; bus.p1_wdata = 32'hCAFEF00D;
    #1;
    chk("t4_oor_gnt1", bus.p1_gnt, 1);
    chk("t4_oor_wr_en", bus.mem_wr_en, 0);
    chk("t4_oor_addr", bus.mem_addr, 32'h100);
    tick();
    chk("t4_oor_rvalid", bus.p1_rvalid, 1);
    chk("t4_oor_err", bus.p1_err, 1);
    chk("t4_oor_rdata", bus.p1_rdata, 0);
    chk("t4_oor_p0_rvalid", bus.p0_rvalid, 0);
    idle();
    bus.p1_req = 1'b1; bus.p1_addr = 32'h0;
    tick();
    chk("t4_idx0_rdata", bus.p1_rdata, 32'h1000_0000);
    chk("t4_idx0_err", bus.p1_err, 0);
    idle();
    bus.p0_req = 1'b1; bus.p0_addr = 32'hFC;
    tick();
    chk("t4_idx63_rdata", bus.p0_rdata, 32'h1000_003F);
    chk("t4_idx63_err", bus.p0_err, 0);
    bus.p0_addr = 32'h100;
    tick();
    chk("t4_idx64_rvalid", bus.p0_rvalid, 1);
    chk("t4_idx64_rdata", bus.p0_rdata, 0);
    chk("t4_idx64_err", bus.p0_err, 1);

    // Same-cycle p0 write / p1 read to one address
    do_reset();
    bus.p0_req = 1'b1; bus.p0_we = 1'b1; bus.p0_addr = 32'h20; bus.p0_wdata = 32'h12345678;
    bus.p1_req = 1'b1; bus.p1_addr = 32'h20;
    #1;
    chk("t5_gnt0", bus.p0_gnt, 1);
    chk("t5_gnt1", bus.p1_gnt, 0);
    chk("t5_wr_en", bus.mem_wr_en, 1);
    tick();
    chk("t5_p0_rvalid", bus.p0_rvalid, 1);
    chk("t5_p1_rvalid_early", bus.p1_rvalid, 0);
    bus.p0_req = 1'b0;
    #1;
    chk("t5_gnt1_next", bus.p1_gnt, 1);
    tick();
    chk("t5_p1_rvalid", bus.p1_rvalid, 1);
    chk("t5_p1_rdata", bus.p1_rdata, 32'h12345678);

    // Reset asserted mid-burst with burst count 3
    do_reset();
    bus.p1_req = 1'b1; bus.p1_lock = 1'b1; bus.p1_we = 1'b1;
    bus.p1_addr = 32'h30; bus.p1_wdata = 32'h55;
    tick();
    tick();
    tick();
    chk("t6_pre_rvalid1", bus.p1_rvalid, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_gnt1", bus.p1_gnt, 0);
    chk("t6_rst_rvalid1", bus.p1_rvalid, 0);
    chk("t6_rst_wr_en", bus.mem_wr_en, 0);
    bus.p0_req = 1'b1; bus.p0_addr = 32'h4;
    tick();
    chk("t6_rst_gnt0", bus.p0_gnt, 0);
    chk("t6_rst_rvalid0", bus.p0_rvalid, 0);
    chk("t6_rst_rvalid1b", bus.p1_rvalid, 0);
    rst_n = 1'b1;
    #1;
    chk("t6_post_gnt0", bus.p0_gnt, 1);
    chk("t6_post_gnt1", bus.p1_gnt, 0);
    tick();
    chk("t6_post_rvalid0", bus.p0_rvalid, 1);
    chk("t6_post_rvalid1", bus.p1_rvalid, 0);
    chk("t6_post_rdata0", bus.p0_rdata, 32'h1000_0001);
    idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
